// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, imem valid/ack fetch and valid/ready hand-off to decode.
// Optional accepted-instruction counter is built only when FETCH_PERF_CNT_EN is defined.
//
// state | meaning
// IDLE  | after reset, no fetch outstanding
// REQ   | fetch request at PC held until imem_ack
// HOLD  | instruction presented to decode until accepted
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  output logic [31:0] pcplus4,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_q;
  logic [31:0] branch_disp;
  logic        accept;

  assign pcplus4     = pc + 32'd4;
  assign branch_disp = branch_offset << 2;
  assign accept      = (state == HOLD) && instr_ready;

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        imem_req = 1'b1;
        if (imem_ack) state_nxt = HOLD;
      end
      HOLD: begin
        instr_valid = 1'b1;
        if (accept) begin
          state_nxt = REQ;
          // jump wins over a taken branch
          if (jump)              pc_nxt = {pcplus4[31:28], instr_q[25:0], 2'b00};
          else if (branch_taken) pc_nxt = pcplus4 + branch_disp;
          else                   pc_nxt = pcplus4;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      pc      <= RESET_PC;
      instr_q <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if ((state == REQ) && imem_ack) instr_q <= imem_rdata;
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign instr     = instr_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    count_q <= 32'h0;
    else if (accept) count_q <= count_q + 32'd1;
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'h0;
`endif

endmodule
